// File: rtl/predictor_pkg.sv
// Shared constants and helpers for the two-level local-history branch predictor.
// Optional BTB is enabled by defining PREDICTOR_BTB_EN.
package predictor_pkg;

  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int HASH_WIDTH_DEF     = 4;
  localparam int HISTORY_LENGTH_DEF = 4;
  localparam int COUNTER_WIDTH_DEF  = 2;
  localparam int BTB_TAG_WIDTH_DEF  = 8;

  // PCs are word aligned, so the index starts above the byte-offset bits
  localparam int IDX_LSB = 2;
  localparam int CNT_MIN = 0;

  function automatic int idx_msb(input int hash_width);
    return hash_width + IDX_LSB - 1;
  endfunction

  function automatic int tag_lsb(input int hash_width);
    return hash_width + IDX_LSB;
  endfunction

  function automatic int tag_msb(input int hash_width, input int tag_width);
    return hash_width + tag_width + IDX_LSB - 1;
  endfunction

  // Weakly not-taken: MSB clear, all lower bits set
  function automatic int cnt_reset(input int counter_width);
    return (1 << (counter_width - 1)) - 1;
  endfunction

  function automatic int cnt_max(input int counter_width);
    return (1 << counter_width) - 1;
  endfunction

endpackage

// File: rtl/predictor_2level_if.sv
// Fetch-stage <-> predictor signal bundle. Target signals exist only with PREDICTOR_BTB_EN.
interface predictor_2level_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Sys_rdy;
  logic                  IFPD_predict_en;
  logic [ADDR_WIDTH-1:0] IFPD_pc;
  logic                  IFPD_feedback_en;
  logic                  IFPD_branch_result;
  logic [ADDR_WIDTH-1:0] IFPD_feedback_pc;
  logic                  PDIF_predict_result;
`ifdef PREDICTOR_BTB_EN
  logic [ADDR_WIDTH-1:0] IFPD_feedback_target;
  logic                  PDIF_target_valid;
  logic [ADDR_WIDTH-1:0] PDIF_target;

  modport master (
    output Sys_rdy, IFPD_predict_en, IFPD_pc, IFPD_feedback_en,
           IFPD_branch_result, IFPD_feedback_pc, IFPD_feedback_target,
    input  PDIF_predict_result, PDIF_target_valid, PDIF_target
  );
  modport slave (
    input  Sys_rdy, IFPD_predict_en, IFPD_pc, IFPD_feedback_en,
           IFPD_branch_result, IFPD_feedback_pc, IFPD_feedback_target,
    output PDIF_predict_result, PDIF_target_valid, PDIF_target
  );
`else
  modport master (
    output Sys_rdy, IFPD_predict_en, IFPD_pc, IFPD_feedback_en,
           IFPD_branch_result, IFPD_feedback_pc,
    input  PDIF_predict_result
  );
  modport slave (
    input  Sys_rdy, IFPD_predict_en, IFPD_pc, IFPD_feedback_en,
           IFPD_branch_result, IFPD_feedback_pc,
    output PDIF_predict_result
  );
`endif
endinterface

// File: rtl/predictor_btb.sv
// Direct-mapped branch target buffer: valid/tag/target per index, written on taken feedback.
module predictor_btb
  import predictor_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int HASH_WIDTH    = HASH_WIDTH_DEF,
  parameter int BTB_TAG_WIDTH = BTB_TAG_WIDTH_DEF
) (
  input  logic                     Sys_clk,
  input  logic                     Sys_rst,
  input  logic                     wr_en,
  input  logic [HASH_WIDTH-1:0]    wr_idx,
  input  logic [BTB_TAG_WIDTH-1:0] wr_tag,
  input  logic [ADDR_WIDTH-1:0]    wr_target,
  input  logic [HASH_WIDTH-1:0]    rd_idx,
  input  logic [BTB_TAG_WIDTH-1:0] rd_tag,
  output logic                     rd_hit,
  output logic [ADDR_WIDTH-1:0]    rd_target
);
  localparam int HASH_SIZE = 1 << HASH_WIDTH;

  logic [HASH_SIZE-1:0]     valid_q, valid_d;
  logic [BTB_TAG_WIDTH-1:0] tag_q    [HASH_SIZE];
  logic [BTB_TAG_WIDTH-1:0] tag_d    [HASH_SIZE];
  logic [ADDR_WIDTH-1:0]    target_q [HASH_SIZE];
  logic [ADDR_WIDTH-1:0]    target_d [HASH_SIZE];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
    end
  end

  always_ff @(posedge Sys_clk or posedge Sys_rst) begin
    if (Sys_rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Payload needs no reset: it is only visible behind a valid bit
  always_ff @(posedge Sys_clk) begin
    if (!Sys_rst) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/predictor_2level.sv
// Two-level local-history direction predictor (per-index BHR selecting a PHT counter).
// Define PREDICTOR_BTB_EN to add the direct-mapped target buffer.
module predictor_2level
  import predictor_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int HASH_WIDTH     = HASH_WIDTH_DEF,
  parameter int HISTORY_LENGTH = HISTORY_LENGTH_DEF,
  parameter int COUNTER_WIDTH  = COUNTER_WIDTH_DEF,
  parameter int BTB_TAG_WIDTH  = BTB_TAG_WIDTH_DEF
) (
  input  logic              Sys_clk,
  input  logic              Sys_rst,
  predictor_2level_if.slave bus
);
  localparam int HASH_SIZE    = 1 << HASH_WIDTH;
  localparam int HISTORY_SIZE = 1 << HISTORY_LENGTH;
  localparam int IDX_MSB      = idx_msb(HASH_WIDTH);
  localparam int TAG_LSB      = tag_lsb(HASH_WIDTH);
  localparam int TAG_MSB      = tag_msb(HASH_WIDTH, BTB_TAG_WIDTH);

  localparam logic [COUNTER_WIDTH-1:0] CNT_RST_VAL = COUNTER_WIDTH'(cnt_reset(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX_VAL = COUNTER_WIDTH'(cnt_max(COUNTER_WIDTH));
  localparam logic [COUNTER_WIDTH-1:0] CNT_MIN_VAL = COUNTER_WIDTH'(CNT_MIN);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);

  logic [HASH_WIDTH-1:0]    pred_idx, fb_idx;
  logic [BTB_TAG_WIDTH-1:0] pred_tag, fb_tag;
  logic                     fb_wr;
  logic [HASH_SIZE-1:0]     entry_taken;

  assign pred_idx = bus.IFPD_pc[IDX_MSB:IDX_LSB];
  assign fb_idx   = bus.IFPD_feedback_pc[IDX_MSB:IDX_LSB];
  assign pred_tag = bus.IFPD_pc[TAG_MSB:TAG_LSB];
  assign fb_tag   = bus.IFPD_feedback_pc[TAG_MSB:TAG_LSB];
  assign fb_wr    = bus.IFPD_feedback_en & bus.Sys_rdy;

  generate
    for (genvar gi = 0; gi < HASH_SIZE; gi++) begin : g_entry
      logic [HISTORY_LENGTH-1:0] bhr_q, bhr_d;
      logic [COUNTER_WIDTH-1:0]  pht_q [HISTORY_SIZE];
      logic [COUNTER_WIDTH-1:0]  pht_d [HISTORY_SIZE];
      logic [COUNTER_WIDTH-1:0]  cnt_cur;
      logic                      wr_en;

      assign wr_en   = fb_wr && (fb_idx == HASH_WIDTH'(gi));
      assign cnt_cur = pht_q[bhr_q];

      // Counter is selected by the history as it was before this branch shifts in
      always_comb begin
        bhr_d = bhr_q;
        pht_d = pht_q;
        if (wr_en) begin
          bhr_d = {bhr_q[HISTORY_LENGTH-2:0], bus.IFPD_branch_result};
          if (bus.IFPD_branch_result) begin
            if (cnt_cur != CNT_MAX_VAL) pht_d[bhr_q] = cnt_cur + CNT_ONE;
          end else begin
            if (cnt_cur != CNT_MIN_VAL) pht_d[bhr_q] = cnt_cur - CNT_ONE;
          end
        end
      end

      always_ff @(posedge Sys_clk or posedge Sys_rst) begin
        if (Sys_rst) begin
          bhr_q <= '0;
          for (int i = 0; i < HISTORY_SIZE; i++) pht_q[i] <= CNT_RST_VAL;
        end else begin
          bhr_q <= bhr_d;
          pht_q <= pht_d;
        end
      end

      assign entry_taken[gi] = cnt_cur[COUNTER_WIDTH-1];
    end
  endgenerate

  assign bus.PDIF_predict_result = ~Sys_rst & bus.IFPD_predict_en & entry_taken[pred_idx];

`ifdef PREDICTOR_BTB_EN
  logic                  btb_hit;
  logic [ADDR_WIDTH-1:0] btb_target;
  logic                  target_valid;

  predictor_btb #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .HASH_WIDTH    (HASH_WIDTH),
    .BTB_TAG_WIDTH (BTB_TAG_WIDTH)
  ) u_btb (
    .Sys_clk   (Sys_clk),
    .Sys_rst   (Sys_rst),
    .wr_en     (fb_wr & bus.IFPD_branch_result),
    .wr_idx    (fb_idx),
    .wr_tag    (fb_tag),
    .wr_target (bus.IFPD_feedback_target),
    .rd_idx    (pred_idx),
    .rd_tag    (pred_tag),
    .rd_hit    (btb_hit),
    .rd_target (btb_target)
  );

  assign target_valid          = ~Sys_rst & bus.IFPD_predict_en & btb_hit;
  assign bus.PDIF_target_valid = target_valid;
  assign bus.PDIF_target       = target_valid ? btb_target : '0;
`else
  logic unused_tag_bits;
  assign unused_tag_bits = ^{pred_tag, fb_tag};
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.IFPD_pc, bus.IFPD_feedback_pc};

endmodule

// File: tb/tb_predictor_2level.sv
// Directed bench for predictor_2level: table of per-cycle vectors plus reset/ready/BTB sequences.
// Build with PREDICTOR_BTB_EN defined to also exercise the target buffer.
module tb_predictor_2level;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  predictor_2level_if #(.ADDR_WIDTH(32)) bus ();

  predictor_2level dut (
    .Sys_clk (clk),
    .Sys_rst (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        fb_en;
    logic        res;
    logic [31:0] fb_pc;
    logic        pen;
    logic [31:0] ppc;
    logic        exp_pred;
  } vec_t;

  localparam int NVEC = 32;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic rdy, input logic fb_en, input logic res,
                              input logic [31:0] fb_pc, input logic pen,
                              input logic [31:0] ppc, input logic exp_pred);
    vec_t r;
    r.rdy = rdy; r.fb_en = fb_en; r.res = res; r.fb_pc = fb_pc;
    r.pen = pen; r.ppc = ppc; r.exp_pred = exp_pred;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end else begin
      $display("ok   %s: %0b", name, act);
    end
  endtask

`ifdef PREDICTOR_BTB_EN
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask
`endif

  // Drive one cycle's inputs on the falling edge; outputs reflect pre-update state
  task automatic drive(input logic rdy, input logic fb_en, input logic res,
                       input logic [31:0] fb_pc, input logic pen, input logic [31:0] ppc);
    @(negedge clk);
    bus.Sys_rdy            = rdy;
    bus.IFPD_feedback_en   = fb_en;
    bus.IFPD_branch_result = res;
    bus.IFPD_feedback_pc   = fb_pc;
    bus.IFPD_predict_en    = pen;
    bus.IFPD_pc            = ppc;
    #1;
  endtask

  initial begin
    // Training on idx 4 (pc 0x10); BHR sequence 0,1,3,7,F then saturation,
    // ready-gating, decrement, same-cycle predict+feedback and idx-5 isolation.
    tbl[0]  = mk(1, 0, 0, 32'h0,  1, 32'h10, 0);
    tbl[1]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[2]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[3]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[4]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[5]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[6]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[7]  = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[8]  = mk(1, 0, 0, 32'h0,  1, 32'h10, 1);
    tbl[9]  = mk(1, 0, 0, 32'h0,  0, 32'h10, 0);
    tbl[10] = mk(1, 0, 0, 32'h0,  1, 32'h50, 1);
    tbl[11] = mk(1, 0, 0, 32'h0,  1, 32'h14, 0);
    tbl[12] = mk(0, 1, 0, 32'h10, 1, 32'h10, 1);
    tbl[13] = mk(0, 1, 0, 32'h10, 1, 32'h10, 1);
    tbl[14] = mk(0, 1, 0, 32'h10, 1, 32'h10, 1);
    tbl[15] = mk(1, 1, 0, 32'h10, 1, 32'h10, 1);
    tbl[16] = mk(1, 0, 0, 32'h0,  1, 32'h10, 0);
    tbl[17] = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[18] = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[19] = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[20] = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[21] = mk(1, 1, 0, 32'h10, 1, 32'h10, 1);
    tbl[22] = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[23] = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[24] = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[25] = mk(1, 1, 1, 32'h10, 1, 32'h10, 1);
    tbl[26] = mk(1, 0, 0, 32'h0,  1, 32'h10, 0);
    tbl[27] = mk(1, 1, 1, 32'h10, 1, 32'h10, 0);
    tbl[28] = mk(1, 0, 0, 32'h0,  1, 32'h10, 1);
    tbl[29] = mk(1, 1, 1, 32'h14, 1, 32'h10, 1);
    tbl[30] = mk(1, 1, 1, 32'h14, 1, 32'h14, 0);
    tbl[31] = mk(1, 0, 0, 32'h0,  1, 32'h10, 1);

    rst                    = 1'b1;
    bus.Sys_rdy            = 1'b1;
    bus.IFPD_predict_en    = 1'b1;
    bus.IFPD_pc            = 32'h10;
    bus.IFPD_feedback_en   = 1'b0;
    bus.IFPD_branch_result = 1'b0;
    bus.IFPD_feedback_pc   = 32'h0;
`ifdef PREDICTOR_BTB_EN
    bus.IFPD_feedback_target = 32'h0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk1("in_reset_pred", bus.PDIF_predict_result, 1'b0);
`ifdef PREDICTOR_BTB_EN
    chk1("in_reset_tv", bus.PDIF_target_valid, 1'b0);
    chk32("in_reset_tgt", bus.PDIF_target, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rdy, tbl[i].fb_en, tbl[i].res, tbl[i].fb_pc, tbl[i].pen, tbl[i].ppc);
      chk1($sformatf("vec%0d", i), bus.PDIF_predict_result, tbl[i].exp_pred);
    end

    // Asynchronous reset mid-run clears outputs at once; feedback during reset is dropped
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk1("pre_reset_pred", bus.PDIF_predict_result, 1'b1);
    #1 rst = 1'b1;
    #1 chk1("async_reset_pred", bus.PDIF_predict_result, 1'b0);
    bus.IFPD_feedback_en   = 1'b1;
    bus.IFPD_branch_result = 1'b1;
    bus.IFPD_feedback_pc   = 32'h10;
    @(posedge clk);
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    rst = 1'b0;
    #1 chk1("post_reset_pred", bus.PDIF_predict_result, 1'b0);

    // Ready low: three taken feedbacks must leave BHR/PHT untouched
    for (int i = 0; i < 3; i++) drive(0, 1, 1, 32'h10, 1, 32'h10);
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk1("rdy_low_pred", bus.PDIF_predict_result, 1'b0);
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 32'h10, 1, 32'h10);
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk1("rdy_low_then_4taken", bus.PDIF_predict_result, 1'b0);

`ifdef PREDICTOR_BTB_EN
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    #2 rst = 1'b0;
    drive(1, 1, 1, 32'h10, 0, 32'h0);
    bus.IFPD_feedback_target = 32'h200;
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk1("btb_hit_tv", bus.PDIF_target_valid, 1'b1);
    chk32("btb_hit_tgt", bus.PDIF_target, 32'h200);
    drive(1, 0, 0, 32'h0, 1, 32'h410);
    chk1("btb_tagmiss_tv", bus.PDIF_target_valid, 1'b0);
    chk32("btb_tagmiss_tgt", bus.PDIF_target, 32'h0);
    drive(1, 1, 0, 32'h10, 0, 32'h0);
    bus.IFPD_feedback_target = 32'h300;
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk32("btb_nt_keeps_tgt", bus.PDIF_target, 32'h200);
    drive(1, 0, 0, 32'h0, 0, 32'h10);
    chk1("btb_pen_low_tv", bus.PDIF_target_valid, 1'b0);
    drive(1, 1, 1, 32'h410, 0, 32'h0);
    bus.IFPD_feedback_target = 32'h400;
    drive(1, 0, 0, 32'h0, 1, 32'h10);
    chk1("btb_replaced_tv", bus.PDIF_target_valid, 1'b0);
    drive(1, 0, 0, 32'h0, 1, 32'h410);
    chk32("btb_new_tgt", bus.PDIF_target, 32'h400);
    #1 rst = 1'b1;
    #1;
    chk1("btb_rst_tv", bus.PDIF_target_valid, 1'b0);
    chk32("btb_rst_tgt", bus.PDIF_target, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/predictor_2level.md
PREDICTOR_2LEVEL -- requirements
Module: predictor_2level

Interface
REQ-001 ADDR_WIDTH, 32, PC width.
REQ-002 HASH_WIDTH, 4, local-history table index width; HASH_SIZE = 2^HASH_WIDTH entries.
REQ-003 HISTORY_LENGTH, 4, per-entry history bits; HISTORY_SIZE = 2^HISTORY_LENGTH counters per entry.
REQ-004 COUNTER_WIDTH, 2, saturating counter width (>=2).
REQ-005 BTB_TAG_WIDTH, 8, BTB tag width; HASH_WIDTH+BTB_TAG_WIDTH+2 <= ADDR_WIDTH.
REQ-006 Sys_clk  in  1  clock, rising edge.
REQ-007 Sys_rst  in  1  reset, asynchronous, active-high.
REQ-008 Sys_rdy  in  1  update enable; low = all state frozen.
REQ-009 IFPD_predict_en  in  1  prediction request.
REQ-010 IFPD_pc  in  ADDR_WIDTH  PC to predict.
REQ-011 IFPD_feedback_en  in  1  resolved-branch update strobe.
REQ-012 IFPD_branch_result  in  1  1 taken, 0 not taken.
REQ-013 IFPD_feedback_pc  in  ADDR_WIDTH  PC of resolved branch.
REQ-014 IFPD_feedback_target  in  ADDR_WIDTH  resolved target (PREDICTOR_BTB_EN only).
REQ-015 PDIF_predict_result  out  1  1 predict taken.
REQ-016 PDIF_target_valid  out  1  BTB hit (PREDICTOR_BTB_EN only).
REQ-017 PDIF_target  out  ADDR_WIDTH  predicted target (PREDICTOR_BTB_EN only).

Function
REQ-018 Index idx = pc[HASH_WIDTH+1:2] for both prediction and feedback paths.
REQ-019 Prediction combinational, zero latency: PDIF_predict_result = MSB of PHT[idx][BHR[idx]] when IFPD_predict_en=1, else 0.
REQ-020 Update on rising Sys_clk when IFPD_feedback_en=1 and Sys_rdy=1; no combinational state writes.
REQ-021 Counter PHT[idx][old BHR[idx]] +1 on taken, -1 on not-taken, saturating at 2^COUNTER_WIDTH-1 and 0.
REQ-022 BHR[idx] <= {BHR[idx][HISTORY_LENGTH-2:0], IFPD_branch_result} in the same edge; counter indexed by pre-shift BHR.
REQ-023 Predict and feedback in same cycle (any idx): prediction returns pre-update state; update visible from next cycle.
REQ-024 Predict and feedback independent ports; feedback never suppressed by predict_en.
REQ-025 Sys_rdy=0: feedback ignored (not queued); prediction still served.
REQ-026 Distinct PCs with equal idx alias to the same entry; no tag check on PHT/BHR.

Reset
REQ-027 Sys_rst=1 immediately clears all BHRs to 0, all counters to 2^(COUNTER_WIDTH-1)-1 (weakly not-taken), all BTB valid bits to 0.
REQ-028 While Sys_rst=1: PDIF_predict_result=0, PDIF_target_valid=0, PDIF_target=0; feedback ignored.
REQ-029 Reset asserted mid-update cancels it; no partial write survives.

Configuration
REQ-030 Macro PREDICTOR_BTB_EN defined: direct-mapped BTB, HASH_SIZE entries {valid, tag=pc[HASH_WIDTH+BTB_TAG_WIDTH+1:HASH_WIDTH+2], target}; taken feedback writes entry (valid=1); not-taken leaves it unchanged; PDIF_target_valid = predict_en & valid & tag match; PDIF_target = stored target on hit, else 0.
REQ-031 Macro undefined: BTB storage, IFPD_feedback_target, PDIF_target_valid, PDIF_target absent; direction behaviour identical.

Structure
REQ-032 Shared package predictor_pkg: counter reset constant, counter saturation limits, index/tag slice width constants.
REQ-033 One sub-module predictor_btb (BTB storage and lookup), instantiated only under PREDICTOR_BTB_EN.

Verification
REQ-034 Reset, predict pc 0x0000_0010 -> PDIF_predict_result=0, target_valid=0.
REQ-035 Five taken feedbacks pc 0x10 (defaults) -> BHR[4]=0xF, PHT[4][0,1,3,7,F]=2, predict 0x10 -> 1; two more taken -> PHT[4][F]=3 (saturates); one not-taken -> PHT[4][F]=2, BHR=0xE, predict -> 0.
REQ-036 Sys_rdy=0 with three taken feedbacks pc 0x10 -> no state change, predict 0x10 -> 0.
REQ-037 Aliasing: taken feedback pc 0x10 also moves pc 0x50 (idx 4); pc 0x14 (idx 5) unchanged.
REQ-038 Same-cycle predict+feedback pc 0x10, counter at 1, taken -> output 0 that cycle; counter 2 next cycle.
REQ-039 PREDICTOR_BTB_EN: taken feedback pc 0x10 target 0x200 -> predict 0x10 gives target_valid=1, target=0x200; predict 0x410 (same idx, tag 0x10) -> target_valid=0; assert Sys_rst mid-run -> all outputs 0 immediately.
